// File: rtl/lpddr2_pkg.sv
// Shared types and constants for the LPDDR2 Avalon-MM bridge.
package lpddr2_pkg;
   localparam int LPDDR2_ADDR_W = 27;
   localparam int LPDDR2_DATA_W = 32;
   localparam logic [LPDDR2_DATA_W/8-1:0] BYTEEN_ALL = '1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_CMD  = 3'd1,
      RD_DATA = 3'd2,
      WR_CMD  = 3'd3,
      RESP    = 3'd4
   } bridge_state_t;
endpackage

// File: rtl/lpddr2_req_arm.sv
// Turns level-held CPU requests into a single accept pulse; a request must be
// released (seen low in IDLE or RESP) before another one is accepted.
module lpddr2_req_arm (
   input  logic clk,
   input  logic rst,
   input  logic rreq,
   input  logic wreq,
   input  logic in_idle,
   input  logic in_resp,
   output logic accept,
   output logic armed
);
   logic armed_q, armed_d;

   assign accept = armed_q & (rreq | wreq) & in_idle;
   assign armed  = armed_q;

   always_comb begin
      armed_d = armed_q;
      if (accept)
         armed_d = 1'b0;
      else if ((in_idle | in_resp) && !rreq && !wreq)
         armed_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) armed_q <= 1'b1;
      else     armed_q <= armed_d;
   end
endmodule

// File: rtl/lpddr2_avalon_bridge.sv
// CPU level-request to single-beat Avalon-MM bridge for the LPDDR2 controller.
// Optional watchdog enabled by defining LPDDR2_TIMEOUT_EN.
module lpddr2_avalon_bridge
   import lpddr2_pkg::*;
#(
   parameter int ADDR_W         = LPDDR2_ADDR_W,
   parameter int DATA_W         = LPDDR2_DATA_W,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W-1:0]   write_data,
   input  logic                rreq,
   input  logic                wreq,
   output logic [DATA_W-1:0]   read_data,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   avm_address,
   output logic                avm_read,
   output logic                avm_write,
   output logic [DATA_W-1:0]   avm_writedata,
   output logic [DATA_W/8-1:0] avm_byteenable,
   input  logic                avm_waitrequest,
   input  logic [DATA_W-1:0]   avm_readdata,
   input  logic                avm_readdatavalid,
   output logic                err
);
   bridge_state_t state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic rd_pend_q, rd_pend_d;
   logic busy_q, busy_d, done_q, done_d;
   logic rd_q, rd_d, wr_q, wr_d, err_q, err_d;
   logic accept, armed;
   logic active;

   lpddr2_req_arm u_arm (
      .clk     (clk),
      .rst     (rst),
      .rreq    (rreq),
      .wreq    (wreq),
      .in_idle (state_q == IDLE),
      .in_resp (state_q == RESP),
      .accept  (accept),
      .armed   (armed)
   );

   assign active = (state_q == RD_CMD) || (state_q == RD_DATA) || (state_q == WR_CMD);

`ifdef LPDDR2_TIMEOUT_EN
   localparam logic [9:0] TO_LIM = 10'(TIMEOUT_CYCLES - 1);
   logic [9:0] cnt_q, cnt_d;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES ^ armed;
`endif

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      rd_pend_d = rd_pend_q;
      err_d     = err_q;
      case (state_q)
         IDLE: if (accept) begin
            addr_d  = address;
            wdata_d = write_data;
            state_d = wreq ? WR_CMD : RD_CMD;
            if (rreq && wreq) err_d = 1'b1;
         end
         // Data may come back in the same cycle the command is accepted.
         RD_CMD: begin
            if (avm_readdatavalid) begin
               rdata_d   = avm_readdata;
               rd_pend_d = 1'b1;
            end
            if (!avm_waitrequest) state_d = RD_DATA;
         end
         RD_DATA: begin
            if (rd_pend_q) begin
               state_d   = RESP;
               rd_pend_d = 1'b0;
            end else if (avm_readdatavalid) begin
               rdata_d = avm_readdata;
               state_d = RESP;
            end
         end
         WR_CMD: if (!avm_waitrequest) state_d = RESP;
         RESP:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (avm_readdatavalid && (state_q != RD_CMD) && (state_q != RD_DATA))
         err_d = 1'b1;
`ifdef LPDDR2_TIMEOUT_EN
      cnt_d = active ? cnt_q + 10'd1 : 10'd0;
      if (active && (cnt_q == TO_LIM) && (state_d != RESP)) begin
         state_d   = RESP;
         err_d     = 1'b1;
         rdata_d   = rdata_q;
         rd_pend_d = 1'b0;
      end
`endif
      busy_d = (state_d == RD_CMD) || (state_d == RD_DATA) || (state_d == WR_CMD);
      done_d = (state_d == RESP);
      rd_d   = (state_d == RD_CMD);
      wr_d   = (state_d == WR_CMD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         rd_pend_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         err_q     <= 1'b0;
`ifdef LPDDR2_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         rd_pend_q <= rd_pend_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         err_q     <= err_d;
`ifdef LPDDR2_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign read_data      = rdata_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign avm_address    = addr_q;
   assign avm_read       = rd_q;
   assign avm_write      = wr_q;
   assign avm_writedata  = wdata_q;
   assign avm_byteenable = '1;
   assign err            = err_q;
endmodule

// File: tb/tb_lpddr2_avalon_bridge.sv
// Directed bench for lpddr2_avalon_bridge.
module tb_lpddr2_avalon_bridge;
   logic        clk, rst;
   logic [26:0] address;
   logic [31:0] write_data, read_data, avm_writedata, avm_readdata;
   logic        rreq, wreq, busy, done, avm_read, avm_write;
   logic [26:0] avm_address;
   logic [3:0]  avm_byteenable;
   logic        avm_waitrequest, avm_readdatavalid, err;
   int tests, fails;

   lpddr2_avalon_bridge #(.ADDR_W(27), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .address(address), .write_data(write_data),
      .rreq(rreq), .wreq(wreq), .read_data(read_data), .busy(busy), .done(done),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      tests = 0; fails = 0;
      rst = 1'b1; address = '0; write_data = '0; rreq = 1'b0; wreq = 1'b0;
      avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check("rst_read_data", 64'(read_data), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_done", 64'(done), 64'h0);
      check("rst_avm_read", 64'(avm_read), 64'h0);
      check("rst_avm_write", 64'(avm_write), 64'h0);
      check("rst_byteen", 64'(avm_byteenable), 64'hF);
      check("rst_err", 64'(err), 64'h0);

      // Test 1: read, readdatavalid two cycles after the command is taken
      rreq = 1'b1; address = 27'h10;
      tick();
      check("t1_avm_read", 64'(avm_read), 64'h1);
      check("t1_avm_addr", 64'(avm_address), 64'h10);
      check("t1_busy", 64'(busy), 64'h1);
      tick();
      check("t1_read_drop", 64'(avm_read), 64'h0);
      check("t1_no_done_early", 64'(done), 64'h0);
      tick();
      avm_readdatavalid = 1'b1; avm_readdata = 32'hDEADBEEF;
      tick();
      avm_readdatavalid = 1'b0; avm_readdata = '0;
      check("t1_done", 64'(done), 64'h1);
      check("t1_read_data", 64'(read_data), 64'hDEADBEEF);
      check("t1_busy_resp", 64'(busy), 64'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t1_held_no_read", 64'(avm_read), 64'h0);
         check("t1_held_no_done", 64'(done), 64'h0);
      end
      rreq = 1'b0;
      tick();

      // Test 2: write stalled by waitrequest for 3 cycles
      wreq = 1'b1; address = 27'h4; write_data = 32'h12345678; avm_waitrequest = 1'b1;
      tick();
      address = 27'h7FF; write_data = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         check("t2_avm_write", 64'(avm_write), 64'h1);
         check("t2_addr_stable", 64'(avm_address), 64'h4);
         check("t2_data_stable", 64'(avm_writedata), 64'h12345678);
         tick();
      end
      check("t2_avm_write_last", 64'(avm_write), 64'h1);
      avm_waitrequest = 1'b0;
      tick();
      check("t2_write_drop", 64'(avm_write), 64'h0);
      check("t2_done", 64'(done), 64'h1);
      check("t2_read_data_kept", 64'(read_data), 64'hDEADBEEF);
      wreq = 1'b0;
      tick();
      check("t2_done_once", 64'(done), 64'h0);

      // Test 4: read, drop rreq for one cycle, then write
      rreq = 1'b1; address = 27'h20;
      tick();
      check("t4_rd_strobe", 64'(avm_read), 64'h1);
      tick();
      avm_readdatavalid = 1'b1; avm_readdata = 32'hAAAA5555;
      tick();
      avm_readdatavalid = 1'b0;
      check("t4_done1", 64'(done), 64'h1);
      rreq = 1'b0;
      tick();
      wreq = 1'b1; address = 27'h30; write_data = 32'hCAFEF00D;
      tick();
      check("t4_wr_strobe", 64'(avm_write), 64'h1);
      check("t4_wr_addr", 64'(avm_address), 64'h30);
      tick();
      check("t4_done2", 64'(done), 64'h1);
      check("t4_read_data", 64'(read_data), 64'hAAAA5555);
      wreq = 1'b0;
      tick();

      // Fast read: data valid in the command-accept cycle
      rreq = 1'b1; address = 27'h40;
      tick();
      avm_readdatavalid = 1'b1; avm_readdata = 32'h0BADF00D;
      tick();
      avm_readdatavalid = 1'b0;
      check("fr_no_done_yet", 64'(done), 64'h0);
      check("fr_read_drop", 64'(avm_read), 64'h0);
      tick();
      check("fr_done", 64'(done), 64'h1);
      check("fr_read_data", 64'(read_data), 64'h0BADF00D);
      check("err_clean", 64'(err), 64'h0);
      rreq = 1'b0;
      tick();

      // Test 3: simultaneous rreq and wreq
      rreq = 1'b1; wreq = 1'b1; address = 27'h50; write_data = 32'h55AA55AA;
      tick();
      check("t3_write", 64'(avm_write), 64'h1);
      check("t3_no_read", 64'(avm_read), 64'h0);
      check("t3_err", 64'(err), 64'h1);
      tick();
      check("t3_done", 64'(done), 64'h1);
      rreq = 1'b0; wreq = 1'b0;
      tick();

      // Stray readdatavalid while idle
      rst = 1'b1; tick(); rst = 1'b0;
      check("rst2_err", 64'(err), 64'h0);
      check("rst2_read_data", 64'(read_data), 64'h0);
      avm_readdatavalid = 1'b1; avm_readdata = 32'h99999999;
      tick();
      avm_readdatavalid = 1'b0;
      check("stray_err", 64'(err), 64'h1);
      check("stray_no_done", 64'(done), 64'h0);
      check("stray_read_data", 64'(read_data), 64'h0);

      // Test 5: reset during RD_DATA, then a late readdatavalid
      rst = 1'b1; tick(); rst = 1'b0;
      rreq = 1'b1; address = 27'h60;
      tick();
      tick();
      check("t5_busy_rd_data", 64'(busy), 64'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0; rreq = 1'b0;
      check("t5_busy_after_rst", 64'(busy), 64'h0);
      check("t5_read_after_rst", 64'(avm_read), 64'h0);
      check("t5_err_after_rst", 64'(err), 64'h0);
      avm_readdatavalid = 1'b1; avm_readdata = 32'h11111111;
      tick();
      avm_readdatavalid = 1'b0;
      check("t5_err", 64'(err), 64'h1);
      check("t5_no_done", 64'(done), 64'h0);
      check("t5_read_data", 64'(read_data), 64'h0);
      tick();
      check("t5_still_idle", 64'(busy), 64'h0);

`ifdef LPDDR2_TIMEOUT_EN
      // Test 6: waitrequest stuck high, watchdog at 8 cycles
      rst = 1'b1; tick(); rst = 1'b0;
      wreq = 1'b1; address = 27'h70; write_data = 32'h0F0F0F0F; avm_waitrequest = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         check("t6_write_held", 64'(avm_write), 64'h1);
         tick();
      end
      check("t6_write_drop", 64'(avm_write), 64'h0);
      check("t6_done", 64'(done), 64'h1);
      check("t6_err", 64'(err), 64'h1);
      wreq = 1'b0; avm_waitrequest = 1'b0;
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
